// File: rtl/fpnew_pkg.sv
// -----------------------------------------------------------------------------
// fpnew_pkg
// Shared definitions for the FSM lane arbiter.
//   MaxNumReq   : largest supported requester count
//   MaxIdxWidth : index width needed for MaxNumReq requesters
//   req_idx_t   : requester index wide enough for any supported NumReq
//   idx_width() : index width for a given requester count, never below 1
// -----------------------------------------------------------------------------
package fpnew_pkg;

    localparam int unsigned MaxNumReq   = 16;
    localparam int unsigned MaxIdxWidth = 4;

    typedef logic [MaxIdxWidth-1:0] req_idx_t;

    function automatic int unsigned idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fpnew_fsm_arb_idq.sv
// -----------------------------------------------------------------------------
// fpnew_fsm_arb_idq
// In-order FIFO of requester IDs for operations issued but not yet returned.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of count and both pointers
//   push, data  : enqueue data at the tail
//   pop         : dequeue the head
//   head        : ID at the head of the queue
//   full, empty : occupancy flags
// The caller must not push when full unless it pops in the same cycle,
// and must not pop when empty.
// -----------------------------------------------------------------------------
module fpnew_fsm_arb_idq #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] data,
    output logic [DataWidth-1:0] head,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;

    logic [DataWidth-1:0] mem [Depth];
    ptr_t                 wr_ptr, rd_ptr;
    logic [CntWidth-1:0]  count;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic ptr_t incr(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= incr(wr_ptr);
            if (pop)  rd_ptr <= incr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CntWidth'(Depth));
    assign empty = (count == '0);

endmodule

// File: rtl/fpnew_fsm_arb.sv
// -----------------------------------------------------------------------------
// fpnew_fsm_arb
// Shares one FSM-based lane unit between NumReq requesters. Requests are
// arbitrated onto the unit input; the requester ID of every accepted
// operation is queued so in-order results are routed back to their owner.
// Adds no latency in either direction.
// Ports:
//   clk_i, rst_ni, flush_i                  : clock, async reset, sync flush
//   req_valid_i/req_ready_o/req_tag_i       : per-requester request
//   unit_valid_o/unit_ready_i/unit_tag_o    : unit input handshake
//   unit_out_valid_i/unit_out_ready_o/
//   unit_out_tag_i                          : unit result handshake
//   rsp_valid_o/rsp_ready_i/rsp_tag_o       : per-requester result
//   busy_o                                  : any operation outstanding
// Build option:
//   FPNEW_FSM_ARB_FIXED_PRIO_EN : fixed priority (lowest index wins) instead
//                                 of round-robin; no rr_ptr register.
// -----------------------------------------------------------------------------
module fpnew_fsm_arb #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         TagType        = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic   [NumReq-1:0]    req_valid_i,
    output logic   [NumReq-1:0]    req_ready_o,
    input  TagType [NumReq-1:0]    req_tag_i,
    output logic                   unit_valid_o,
    input  logic                   unit_ready_i,
    output TagType                 unit_tag_o,
    input  logic                   unit_out_valid_i,
    output logic                   unit_out_ready_o,
    input  TagType                 unit_out_tag_i,
    output logic   [NumReq-1:0]    rsp_valid_o,
    input  logic   [NumReq-1:0]    rsp_ready_i,
    output TagType [NumReq-1:0]    rsp_tag_o,
    output logic                   busy_o
);

    import fpnew_pkg::*;

    localparam int unsigned IdxWidth = idx_width(NumReq);

    typedef logic [IdxWidth-1:0] idx_t;

    idx_t grant, head;
    logic any_valid, id_full, id_empty, can_push, in_hs, out_hs;

    assign any_valid = |req_valid_i;

`ifdef FPNEW_FSM_ARB_FIXED_PRIO_EN
    // Downward scan so the lowest valid index is the last one written.
    always_comb begin
        grant = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i]) grant = idx_t'(i);
        end
    end
`else
    idx_t rr_ptr;
    idx_t cand;
    logic found;

    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            cand = idx_t'((32'(rr_ptr) + 32'(i)) % NumReq);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (!flush_i && in_hs) begin
            rr_ptr <= (grant == idx_t'(NumReq - 1)) ? '0 : grant + idx_t'(1);
        end
    end
`endif

    // A result leaving in the same cycle frees a slot, so a full queue can
    // still accept a new operation then.
    assign out_hs       = unit_out_valid_i & unit_out_ready_o;
    assign can_push     = ~id_full | out_hs;
    assign unit_valid_o = any_valid & can_push;
    assign unit_tag_o   = req_tag_i[grant];
    assign in_hs        = unit_valid_o & unit_ready_i;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = any_valid & unit_ready_i & can_push;
    end

    assign unit_out_ready_o = rsp_ready_i[head] & ~id_empty;

    always_comb begin
        rsp_valid_o       = '0;
        rsp_valid_o[head] = unit_out_valid_i & ~id_empty;
        for (int i = 0; i < NumReq; i++) begin
            rsp_tag_o[i] = unit_out_tag_i;
        end
    end

    assign busy_o = ~id_empty;

    fpnew_fsm_arb_idq #(
        .Depth     (MaxOutstanding),
        .DataWidth (IdxWidth)
    ) i_idq (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (flush_i),
        .push  (in_hs & ~flush_i),
        .pop   (out_hs & ~flush_i),
        .data  (grant),
        .head  (head),
        .full  (id_full),
        .empty (id_empty)
    );

endmodule

// File: tb/tb_fpnew_fsm_arb.sv
module tb_fpnew_fsm_arb;

    localparam int N = 3;
    localparam int M = 4;
`ifdef FPNEW_FSM_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    typedef logic [7:0] tag_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic   [N-1:0]   req_valid = '0;
    logic   [N-1:0]   req_ready;
    tag_t   [N-1:0]   req_tag = '0;
    logic             unit_valid;
    logic             unit_ready = 1'b0;
    tag_t             unit_tag;
    logic             unit_out_valid = 1'b0;
    logic             unit_out_ready;
    tag_t             unit_out_tag = '0;
    logic   [N-1:0]   rsp_valid;
    logic   [N-1:0]   rsp_ready = '0;
    tag_t   [N-1:0]   rsp_tag;
    logic             busy;

    always #5 clk = ~clk;

    fpnew_fsm_arb #(
        .NumReq         (N),
        .MaxOutstanding (M),
        .TagType        (tag_t)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_tag_i        (req_tag),
        .unit_valid_o     (unit_valid),
        .unit_ready_i     (unit_ready),
        .unit_tag_o       (unit_tag),
        .unit_out_valid_i (unit_out_valid),
        .unit_out_ready_o (unit_out_ready),
        .unit_out_tag_i   (unit_out_tag),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_tag_o        (rsp_tag),
        .busy_o           (busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: outstanding owners in issue order, plus the
    // round-robin starting point.
    int q[$];
    int rr = 0;
    bit push_s, pop_s;
    int g_s;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (FixedPrio) begin
            for (int k = 0; k < N; k++) if (req_valid[k]) return k;
            return 0;
        end
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic sample();
        bit any, popm, canp;
        int g;
        logic [31:0] exp_ready, exp_rsp;
        #2;
        any  = |req_valid;
        g    = model_grant();
        popm = unit_out_valid && q.size() > 0 && rsp_ready[q[0]];
        canp = (q.size() < M) || popm;
        exp_ready = (any && unit_ready && canp) ? (32'd1 << g) : 32'd0;
        exp_rsp   = (unit_out_valid && q.size() > 0) ? (32'd1 << q[0]) : 32'd0;
        chk("unit_valid", 32'(unit_valid), 32'(any && canp));
        chk("req_ready", 32'(req_ready), exp_ready);
        if (any) chk("unit_tag", 32'(unit_tag), 32'(req_tag[g]));
        chk("rsp_valid", 32'(rsp_valid), exp_rsp);
        chk("unit_out_ready", 32'(unit_out_ready), 32'(q.size() > 0 && rsp_ready[q[0]]));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("rsp_tag", 32'(rsp_tag), 32'({N{unit_out_tag}}));
        push_s = any && unit_ready && canp;
        pop_s  = popm;
        g_s    = g;
    endtask

    task automatic tick();
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop_s) void'(q.pop_front());
            if (push_s) begin
                q.push_back(g_s);
                rr = (g_s + 1) % N;
            end
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        req_valid = '0;
        unit_ready = 1'b0;
        unit_out_valid = 1'b0;
        rsp_ready = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_unit_valid", 32'(unit_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_unit_out_ready", 32'(unit_out_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        q.delete();
        rr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int acc;
        #1;
        do_reset();

        // Two requesters held valid: grants and results alternate 0,1,...
        req_valid = 3'b011;
        unit_ready = 1'b1;
        unit_out_valid = 1'b1;
        rsp_ready = 3'b111;
        for (int c = 0; c < 8; c++) begin
            req_tag = {8'($urandom), 8'($urandom), 8'($urandom)};
            unit_out_tag = 8'($urandom);
            sample();
`ifndef FPNEW_FSM_ARB_FIXED_PRIO_EN
            chk("s1_grant", 32'(req_ready), (c % 2) ? 32'd2 : 32'd1);
            if (c > 0) chk("s1_rsp_order", 32'(rsp_valid), (c % 2) ? 32'd1 : 32'd2);
`endif
            tick();
        end

        // Unit never returns: exactly M accepts, then stalled and busy.
        do_reset();
        req_valid = 3'b001;
        unit_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            sample();
            if (req_ready[0]) acc++;
            tick();
        end
        chk("s2_accepts", 32'(acc), 32'd4);
        sample();
        chk("s2_stalled", 32'(req_ready), 32'd0);
        chk("s2_busy", 32'(busy), 32'd1);
        tick();

        // Full queue: pop and push in one cycle, new owner lands at the tail.
        req_valid = 3'b010;
        req_tag[1] = 8'h5a;
        unit_out_valid = 1'b1;
        rsp_ready = 3'b111;
        sample();
        chk("s3_push_on_full", 32'(req_ready), 32'd2);
        chk("s3_pop_on_full", 32'(unit_out_ready), 32'd1);
        chk("s3_unit_tag", 32'(unit_tag), 32'h5a);
        tick();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("s3_order", 32'(rsp_valid), (i == 3) ? 32'd2 : 32'd1);
            tick();
        end
        sample();
        chk("s3_drained", 32'(busy), 32'd0);
        tick();

        // Backpressure from the owner for three cycles, then delivery.
        do_reset();
        req_valid = 3'b100;
        unit_ready = 1'b1;
        cycle();
        req_valid = '0;
        unit_out_valid = 1'b1;
        unit_out_tag = 8'hc3;
        rsp_ready = 3'b011;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("s4_held_ready", 32'(unit_out_ready), 32'd0);
            chk("s4_held_valid", 32'(rsp_valid), 32'd4);
            tick();
        end
        rsp_ready = 3'b100;
        sample();
        chk("s4_release", 32'(unit_out_ready), 32'd1);
        chk("s4_tag", 32'(rsp_tag[2]), 32'hc3);
        tick();
        unit_out_valid = 1'b0;
        sample();
        chk("s4_done", 32'(busy), 32'd0);
        tick();

        // Flush with three outstanding; arbitration pointer survives.
        do_reset();
        unit_ready = 1'b1;
        req_valid = 3'b001; cycle();
        req_valid = 3'b010; cycle();
        req_valid = 3'b001; cycle();
        req_valid = '0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        sample();
        chk("s5_busy", 32'(busy), 32'd0);
        tick();
        req_valid = 3'b101;
        sample();
        chk("s5_rr_kept", 32'(req_ready), FixedPrio ? 32'd1 : 32'd4);
        tick();

`ifdef FPNEW_FSM_ARB_FIXED_PRIO_EN
        // Requesters 0 and 2 always valid: 0 always wins.
        do_reset();
        req_valid = 3'b101;
        unit_ready = 1'b1;
        unit_out_valid = 1'b1;
        rsp_ready = 3'b111;
        for (int c = 0; c < 6; c++) begin
            sample();
            chk("s6_fixed", 32'(req_ready), 32'd1);
            tick();
        end
`endif

        // Reset while operations are outstanding drops them.
        do_reset();
        req_valid = 3'b001;
        unit_ready = 1'b1;
        cycle();
        cycle();
        do_reset();
        sample();
        chk("midrst_busy", 32'(busy), 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req_valid = 3'($urandom_range(0, 7));
            req_tag = {8'($urandom), 8'($urandom), 8'($urandom)};
            unit_ready = ($urandom % 4) != 0;
            unit_out_valid = ($urandom % 3) != 0;
            unit_out_tag = 8'($urandom);
            rsp_ready = 3'($urandom_range(0, 7));
            flush = ($urandom % 40) == 0;
            cycle();
        end
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
